// File: rtl/mult4u_pkg.sv
// mult4u_pkg: shared state encoding and mod-3 residue helpers for the multiplier checker.
//   RES_W  - width of a residue (values 0..2)
//   mod3_4 - residue of a 4-bit value
//   mod3_8 - residue of an 8-bit value
package mult4u_pkg;

    localparam int RES_W = 2;

    typedef enum logic [1:0] {IDLE, SETTLE, OUT} state_e;

    function automatic logic [RES_W-1:0] mod3_4(input logic [3:0] x);
        return RES_W'(x % 4'd3);
    endfunction

    function automatic logic [RES_W-1:0] mod3_8(input logic [7:0] x);
        return RES_W'(x % 8'd3);
    endfunction

endpackage

// File: rtl/mult4u_mod3_res.sv
// mult4u_mod3_res: combinational mod-3 residue of an 8-bit product.
//   val_i - 8-bit value
//   res_o - residue 0..2
module mult4u_mod3_res
    import mult4u_pkg::*;
(
    input  logic [7:0]       val_i,
    output logic [RES_W-1:0] res_o
);

    assign res_o = mod3_8(val_i);

endmodule

// File: rtl/mult4u_residue_checker.sv
// mult4u_residue_checker: registers operands for an external 4x4 multiplier, samples the
// product after a settle time, checks it with a mod-3 residue and re-samples on mismatch.
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid/in_ready     - operand handshake, in_a/in_b operands
//   mul_a/mul_b/mul_p     - registered operands to and product from the multiplier
//   out_valid/out_ready   - result handshake; out_p, out_err, out_retries result fields
//   err_clr/err_cnt       - clear and saturating count of results delivered with out_err
module mult4u_residue_checker
    import mult4u_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_RETRY     = 2,
    parameter int RETRY_W       = 2,
    parameter int ERR_W         = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         in_a,
    input  logic [3:0]         in_b,
    output logic [3:0]         mul_a,
    output logic [3:0]         mul_b,
    input  logic [7:0]         mul_p,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [7:0]         out_p,
    output logic               out_err,
    output logic [RETRY_W-1:0] out_retries,
    input  logic               err_clr,
    output logic [ERR_W-1:0]   err_cnt
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e             state_q, state_d;
    logic [3:0]         a_q, a_d, b_q, b_d;
    logic [RES_W-1:0]   ra_q, ra_d, rb_q, rb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d, retries_q, retries_d;
    logic [7:0]         p_q, p_d;
    logic               err_q, err_d;
    logic [ERR_W-1:0]   ecnt_q, ecnt_d;

    logic [RES_W-1:0]   rp;
    logic [3:0]         rr_prod;
    logic               accept, sample, match, finish;

    mult4u_mod3_res u_res (
        .val_i (mul_p),
        .res_o (rp)
    );

    // ra*rb is at most 4, so a 4-bit product reduced by mod3_4 suffices
    assign rr_prod  = {2'b00, ra_q} * {2'b00, rb_q};
    assign match    = mod3_4(rr_prod) == rp;
    assign sample   = (state_q == SETTLE) && (cnt_q == '0);
    assign finish   = sample && (match || retry_q == RETRY_W'(MAX_RETRY));
    assign in_ready = (state_q == IDLE) || (state_q == OUT && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        p_d       = p_q;
        err_d     = err_q;
        retries_d = retries_q;
        if (accept) begin
            state_d = SETTLE;
            a_d     = in_a;
            b_d     = in_b;
            ra_d    = mod3_4(in_a);
            rb_d    = mod3_4(in_b);
            cnt_d   = CNT_RELOAD;
            retry_d = '0;
        end else if (sample) begin
            p_d = mul_p;
            if (finish) begin
                state_d   = OUT;
                err_d     = ~match;
                retries_d = retry_q;
            end else begin
                retry_d = retry_q + 1'b1;
                cnt_d   = CNT_RELOAD;
            end
        end else if (state_q == SETTLE) begin
            cnt_d = cnt_q - 1'b1;
        end else if (state_q == OUT && out_ready) begin
            state_d = IDLE;
        end
        // clear wins over a coincident increment
        ecnt_d = err_clr ? '0 : (finish && !match && ecnt_q != '1) ? ecnt_q + 1'b1 : ecnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            ra_q      <= '0;
            rb_q      <= '0;
            cnt_q     <= '0;
            retry_q   <= '0;
            p_q       <= '0;
            err_q     <= 1'b0;
            retries_q <= '0;
            ecnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            ra_q      <= ra_d;
            rb_q      <= rb_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            p_q       <= p_d;
            err_q     <= err_d;
            retries_q <= retries_d;
            ecnt_q    <= ecnt_d;
        end
    end

    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign out_valid   = state_q == OUT;
    assign out_p       = p_q;
    assign out_err     = err_q;
    assign out_retries = retries_q;
    assign err_cnt     = ecnt_q;

endmodule
